// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, parity modes, counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_t;

    localparam string PAR_NONE = "NONE";
    localparam string PAR_ODD  = "ODD";
    localparam string PAR_EVEN = "EVEN";

    // Width of a bit timer that must hold values up to n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input with falling-edge detect.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    // Marks when prev_q holds a real post-reset sample, so a line that is
    // already low at reset release is not mistaken for a falling edge.
    logic [2:0] fill_q;

    // Synchroniser chain, delayed copy for edge detect, and fill tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            fill_q <= 3'b000;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    assign dout = s2_q;
    assign fall = fill_q[2] & prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling deserialiser with a one-entry valid/ready output buffer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BYTESIZE = 8,
    parameter string       PARITY   = "NONE",
    parameter int unsigned STOPSIZE = 1,
    parameter int unsigned N_BIT    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rxd,
    output logic [BYTESIZE-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                err_frame,
    output logic                err_parity,
    output logic                err_overrun,
    output logic                status_irq,
    output logic                status_err
);

    localparam int unsigned   CW      = cnt_width(N_BIT);
    localparam logic [CW-1:0] HALF    = CW'(N_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL    = CW'(N_BIT - 1);
    localparam bit            HAS_PAR = (PARITY != PAR_NONE);
    localparam bit            IS_ODD  = (PARITY == PAR_ODD);

    logic rxd_s;
    logic start_edge;

    uart_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (uart_rxd),
        .dout (rxd_s),
        .fall (start_edge)
    );

    uart_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTESIZE-1:0] shift_q, shift_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                tick;
    logic                commit;

    assign tick = (cnt_q == '0);

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic; every tick is a mid-bit sample point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        commit  = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = tick ? FULL : cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StStart;
                    cnt_d   = HALF;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rxd_s ? StIdle : StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rxd_s, shift_q[BYTESIZE-1:1]};
                    if (bit_q == 3'(BYTESIZE - 1)) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    perr_d  = rxd_s != ((^shift_q) ^ IS_ODD);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == 3'(STOPSIZE - 1)) begin
                        // Re-arm at mid-stop-bit so back-to-back frames are caught.
                        state_d = StIdle;
                        commit  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // One-entry output buffer: load when free or draining this cycle, else flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else if (commit) begin
            if (!rx_valid || rx_ready) begin
                rx_data     <= shift_q;
                rx_valid    <= 1'b1;
                err_frame   <= ferr_d;
                err_parity  <= perr_q;
                err_overrun <= 1'b0;
            end else begin
                err_overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign status_irq = rx_valid;
    assign status_err = rx_valid & (err_frame | err_parity | err_overrun);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       ready_a = 1'b1;
    logic       ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       va, vb, fa, fb, pa, pb, oa, ob, ia, ib, sa, sb;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.BYTESIZE(8), .PARITY("NONE"), .STOPSIZE(1), .N_BIT(5)) dut_a (
        .clk(clk), .rst(rst), .uart_rxd(rxd_a), .rx_data(data_a), .rx_valid(va),
        .rx_ready(ready_a), .err_frame(fa), .err_parity(pa), .err_overrun(oa),
        .status_irq(ia), .status_err(sa)
    );

    uart_rx #(.BYTESIZE(8), .PARITY("EVEN"), .STOPSIZE(1), .N_BIT(5)) dut_b (
        .clk(clk), .rst(rst), .uart_rxd(rxd_b), .rx_data(data_b), .rx_valid(vb),
        .rx_ready(ready_b), .err_frame(fb), .err_parity(pb), .err_overrun(ob),
        .status_irq(ib), .status_err(sb)
    );

    // Capture every completed transfer, sampled on the falling edge.
    int         na = 0, nb = 0;
    logic [7:0] ca_d, cb_d;
    logic       ca_f, ca_p, ca_o, ca_i, ca_s, cb_f, cb_p, cb_o, cb_i, cb_s;
    int         ca_cyc, cb_cyc;
    always @(negedge clk) begin
        if (va && ready_a) begin
            na <= na + 1; ca_d <= data_a; ca_f <= fa; ca_p <= pa; ca_o <= oa;
            ca_i <= ia; ca_s <= sa; ca_cyc <= cyc;
        end
        if (vb && ready_b) begin
            nb <= nb + 1; cb_d <= data_b; cb_f <= fb; cb_p <= pb; cb_o <= ob;
            cb_i <= ib; cb_s <= sb; cb_cyc <= cyc;
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else rxd_a = v;
    endtask

    // One frame at 5 clk/bit; t0 is the cycle count just after the start bit is driven.
    task automatic send(input bit sel, input logic [7:0] d, input bit hp, input bit pbit,
                        input bit sbit, input bit hold_low, output int t0);
        @(posedge clk);
        #1 drive(sel, 1'b0);
        t0 = cyc;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 drive(sel, d[i]);
            repeat (5) @(posedge clk);
        end
        if (hp) begin
            #1 drive(sel, pbit);
            repeat (5) @(posedge clk);
        end
        #1 drive(sel, sbit);
        repeat (5) @(posedge clk);
        #1 if (!hold_low) drive(sel, 1'b1);
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         hp;
        bit         pbit;
        bit         sbit;
        logic [7:0] exp_d;
        bit         exp_f;
        bit         exp_p;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int t0, n0, lat;
        logic [7:0] frame21;

        vecs[0]  = '{0, 8'h48, 0, 0, 1, 8'h48, 0, 0};
        vecs[1]  = '{0, 8'h65, 0, 0, 1, 8'h65, 0, 0};
        vecs[2]  = '{0, 8'h00, 0, 0, 1, 8'h00, 0, 0};
        vecs[3]  = '{0, 8'hFF, 0, 0, 1, 8'hFF, 0, 0};
        vecs[4]  = '{0, 8'h6C, 0, 0, 0, 8'h6C, 1, 0};
        vecs[5]  = '{1, 8'h07, 1, 0, 1, 8'h07, 0, 1};
        vecs[6]  = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0};
        vecs[7]  = '{1, 8'h00, 1, 0, 1, 8'h00, 0, 0};
        vecs[8]  = '{1, 8'h80, 1, 0, 1, 8'h80, 0, 1};
        vecs[9]  = '{1, 8'hFF, 1, 0, 1, 8'hFF, 0, 0};
        vecs[10] = '{1, 8'h03, 1, 0, 0, 8'h03, 1, 0};
        vecs[11] = '{1, 8'hA5, 1, 1, 1, 8'hA5, 0, 1};

        // Reset state, with the line held low through reset release.
        rxd_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", va, 0);
        check("rst_data", data_a, 0);
        check("rst_flags", {fa, pa, oa, ia, sa}, 0);
        rst = 1'b0;
        repeat (70) @(posedge clk);
        #1 check("low_at_release_no_frame", na, 0);
        rxd_a = 1'b1;
        repeat (10) @(posedge clk);

        // Table of single frames with ready held high.
        for (int i = 0; i < 12; i++) begin
            n0 = vecs[i].sel ? nb : na;
            send(vecs[i].sel, vecs[i].d, vecs[i].hp, vecs[i].pbit, vecs[i].sbit, 0, t0);
            repeat (3) @(posedge clk);
            #1;
            lat = vecs[i].hp ? 55 : 50;
            if (vecs[i].sel) begin
                check($sformatf("v%0d_count", i), nb, n0 + 1);
                check($sformatf("v%0d_data", i), cb_d, vecs[i].exp_d);
                check($sformatf("v%0d_ferr", i), cb_f, vecs[i].exp_f);
                check($sformatf("v%0d_perr", i), cb_p, vecs[i].exp_p);
                check($sformatf("v%0d_ovr", i), cb_o, 0);
                check($sformatf("v%0d_irq", i), cb_i, 1);
                check($sformatf("v%0d_serr", i), cb_s, vecs[i].exp_f | vecs[i].exp_p);
                check($sformatf("v%0d_latency", i), cb_cyc - t0, lat);
            end else begin
                check($sformatf("v%0d_count", i), na, n0 + 1);
                check($sformatf("v%0d_data", i), ca_d, vecs[i].exp_d);
                check($sformatf("v%0d_ferr", i), ca_f, vecs[i].exp_f);
                check($sformatf("v%0d_perr", i), ca_p, vecs[i].exp_p);
                check($sformatf("v%0d_ovr", i), ca_o, 0);
                check($sformatf("v%0d_irq", i), ca_i, 1);
                check($sformatf("v%0d_serr", i), ca_s, vecs[i].exp_f);
                check($sformatf("v%0d_latency", i), ca_cyc - t0, lat);
            end
            repeat (2) @(posedge clk);
        end

        // One-cycle glitch is rejected, then a real frame follows.
        n0 = na;
        @(posedge clk);
        #1 rxd_a = 1'b0;
        @(posedge clk);
        #1 rxd_a = 1'b1;
        repeat (60) @(posedge clk);
        #1 check("glitch_no_frame", na, n0);
        send(0, 8'h65, 0, 0, 1, 0, t0);
        repeat (3) @(posedge clk);
        #1 check("after_glitch_count", na, n0 + 1);
        check("after_glitch_data", ca_d, 8'h65);

        // Framing error followed by a break of three bit times.
        n0 = na;
        send(0, 8'h55, 0, 0, 0, 1, t0);
        repeat (15) @(posedge clk);
        #1 rxd_a = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("break_count", na, n0 + 1);
        check("break_data", ca_d, 8'h55);
        check("break_ferr", ca_f, 1);
        check("break_serr", ca_s, 1);
        send(0, 8'h6C, 0, 0, 1, 0, t0);
        repeat (3) @(posedge clk);
        #1 check("after_break_data", ca_d, 8'h6C);
        check("after_break_ferr", ca_f, 0);
        check("after_break_count", na, n0 + 2);

        // Overrun: second byte dropped while the first is held.
        ready_a = 1'b0;
        n0 = na;
        send(0, 8'h48, 0, 0, 1, 0, t0);
        repeat (2) @(posedge clk);
        #1 check("hold_ovr_clear", oa, 0);
        send(0, 8'h69, 0, 0, 1, 0, t0);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_valid", va, 1);
        check("ovr_data", data_a, 8'h48);
        check("ovr_flag", oa, 1);
        check("ovr_irq", ia, 1);
        check("ovr_serr", sa, 1);
        check("ovr_no_transfer", na, n0);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
        check("pulse_valid_low", va, 0);
        check("pulse_count", na, n0 + 1);
        check("pulse_data", ca_d, 8'h48);
        check("pulse_ovr", ca_o, 1);
        ready_a = 1'b1;
        send(0, 8'h21, 0, 0, 1, 0, t0);
        repeat (3) @(posedge clk);
        #1 check("post_ovr_data", ca_d, 8'h21);
        check("post_ovr_flag", ca_o, 0);

        // Commit in the same cycle as a transfer of the held byte.
        ready_a = 1'b0;
        send(0, 8'h11, 0, 0, 1, 0, t0);
        repeat (2) @(posedge clk);
        n0 = na;
        fork
            send(0, 8'h22, 0, 0, 1, 0, t0);
            begin
                @(posedge clk);
                repeat (49) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        #1;
        check("same_cycle_count", na, n0 + 1);
        check("same_cycle_old", ca_d, 8'h11);
        check("same_cycle_valid", va, 1);
        check("same_cycle_new", data_a, 8'h22);
        check("same_cycle_ovr", oa, 0);

        // Reset during data bit 3 while a byte is held.
        frame21 = 8'h21;
        @(posedge clk);
        #1 rxd_a = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rxd_a = frame21[i];
            repeat ((i < 3) ? 5 : 2) @(posedge clk);
        end
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", va, 0);
        check("midrst_data", data_a, 0);
        check("midrst_flags", {fa, pa, oa, ia, sa}, 0);
        rxd_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (80) @(posedge clk);
        #1 check("midrst_no_byte", va, 0);
        ready_a = 1'b1;
        n0 = na;
        send(0, 8'h21, 0, 0, 1, 0, t0);
        repeat (3) @(posedge clk);
        #1 check("postrst_count", na, n0 + 1);
        check("postrst_data", ca_d, 8'h21);
        check("postrst_flags", {ca_f, ca_p, ca_o}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
